// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier that borrows a shared ALU for every add.
// Optional MUL_SEQ_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.

`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 4
`endif
`ifndef ALU_MODE_ADD
`define ALU_MODE_ADD 0
`endif

module mul_seq #(
    parameter int BIT_COUNT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIT_COUNT-1:0]       op_a,
    input  logic [BIT_COUNT-1:0]       op_b,
    output logic                       busy,
    output logic                       done,
    output logic [BIT_COUNT-1:0]       result,
    output logic                       alu_req,
    input  logic                       alu_gnt,
    output logic [BIT_COUNT-1:0]       alu_a,
    output logic [BIT_COUNT-1:0]       alu_b,
    output logic [`ALU_MODE_COUNT-1:0] alu_mode,
    input  logic [BIT_COUNT-1:0]       alu_c
);

    localparam int MW = `ALU_MODE_COUNT;
    localparam logic [MW-1:0] MODE_ADD = MW'(1 << `ALU_MODE_ADD);

    // IDLE | waiting for start
    // ACC  | acc += (q[0] ? m : 0) through the ALU
    // DBL  | m += m through the ALU, shift q, advance step count
    // DONE | one-cycle completion, result valid
    typedef enum logic [1:0] {IDLE, ACC, DBL, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIT_COUNT-1:0] m;
    logic [BIT_COUNT-1:0] q;
    logic [BIT_COUNT-1:0] acc;
    logic [2:0]           cnt;
    logic                 last_step;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last_step = (q >> 1) == '0;
`else
    assign last_step = cnt == 3'(BIT_COUNT - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (alu_gnt) state_nxt = DBL;
            DBL:     if (alu_gnt) state_nxt = last_step ? DONE : ACC;
            DONE:    state_nxt = start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m      <= '0;
            q      <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m   <= op_a;
                        q   <= op_b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ACC: if (alu_gnt) acc <= alu_c;
                DBL: begin
                    if (alu_gnt) begin
                        m   <= alu_c;
                        q   <= q >> 1;
                        cnt <= cnt + 3'd1;
                        // acc is already final once the last doubling is granted
                        if (last_step) result <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state == ACC) || (state == DBL);
        done     = (state == DONE);
        alu_req  = busy;
        alu_a    = '0;
        alu_b    = '0;
        alu_mode = '0;
        case (state)
            ACC: begin
                alu_a    = acc;
                alu_b    = q[0] ? m : '0;
                alu_mode = MODE_ADD;
            end
            DBL: begin
                alu_a    = m;
                alu_b    = m;
                alu_mode = MODE_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter BIT_COUNT, default 8, giving the operand, result and ALU datapath width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a multiply.
REQ-005 SHALL have port op_a, input, BIT_COUNT, multiplicand.
REQ-006 SHALL have port op_b, input, BIT_COUNT, multiplier.
REQ-007 SHALL have port busy, output, 1, high while in ACC or DBL.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port result, output, BIT_COUNT, low BIT_COUNT bits of op_a*op_b; held until the next accepted start.
REQ-010 SHALL have port alu_req, output, 1, request for the shared ALU; equals busy.
REQ-011 SHALL have port alu_gnt, input, 1, ALU granted this cycle.
REQ-012 SHALL have ports alu_a and alu_b, output, BIT_COUNT each, ALU operands.
REQ-013 SHALL have port alu_mode, output, `ALU_MODE_COUNT, one-hot ALU mode per param.vh.
REQ-014 SHALL have port alu_c, input, BIT_COUNT, combinational ALU result.

Function
REQ-015 SHALL implement states IDLE, ACC, DBL and DONE, plus internal registers m (multiplicand), q (multiplier), acc and a 3-bit step count cnt.
REQ-016 SHALL, in IDLE or DONE with start=1, latch m=op_a, q=op_b, acc=0 and cnt=0, then enter ACC; start SHALL be ignored in ACC and DBL.
REQ-017 SHALL go from DONE to IDLE when start=0.
REQ-018 SHALL, in ACC, drive alu_a=acc, alu_b=(q[0] ? m : 0) and alu_mode with only ALU_MODE_ADD set; when alu_gnt=1, acc<=alu_c and the state goes to DBL.
REQ-019 SHALL, in DBL, drive alu_a=m, alu_b=m and ALU_MODE_ADD; when alu_gnt=1, m<=alu_c, q<=q>>1 and cnt<=cnt+1, and the next state is DONE if cnt==BIT_COUNT-1, otherwise ACC.
REQ-020 SHALL, in ACC or DBL with alu_gnt=0, hold all state and registers, keeping alu_req and the operands stable (stall).
REQ-021 SHALL drive alu_mode=0, alu_a=0 and alu_b=0 in IDLE and DONE.
REQ-022 SHALL assert done only in DONE, and update result from acc on the DBL-to-DONE transition.
REQ-023 SHALL discard arithmetic overflow beyond BIT_COUNT bits (modulo 2^BIT_COUNT).
REQ-024 SHALL, with alu_gnt held at 1 and no early exit, use 2*BIT_COUNT ALU cycles and raise done in cycle 2*BIT_COUNT+1 after the cycle start was sampled (17 for BIT_COUNT=8).

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE and clear m, q, acc, cnt and result to 0, with busy, done and alu_req at 0, overriding start and any operation in progress.
REQ-026 SHALL, after a reset mid-operation, produce no done pulse for the aborted operation.

Configuration
REQ-027 SHALL, with macro MUL_SEQ_EARLY_EXIT_EN defined, transition DBL to DONE when alu_gnt=1 and q>>1==0, regardless of cnt.
REQ-028 SHALL, without MUL_SEQ_EARLY_EXIT_EN, always execute the full 2*BIT_COUNT ALU cycles; results SHALL be identical in both builds.

Verification
REQ-029 SHALL cover: op_a=13, op_b=11, alu_gnt=1, macro off -> done in cycle 17, result=0x8F.
REQ-030 SHALL cover: op_a=0xFF, op_b=0xFF -> result=0x01 (overflow discarded).
REQ-031 SHALL cover: op_a=13, op_b=11 with alu_gnt=0 for 3 cycles during DBL of step 2 -> alu_a, alu_b and alu_mode stable while stalled, done in cycle 20, result=0x8F.
REQ-032 SHALL cover: rst=1 in cycle 6 of an operation -> IDLE next cycle, busy=0, result=0, no done; a new start of 2*3 -> result=6.
REQ-033 SHALL cover: MUL_SEQ_EARLY_EXIT_EN defined, op_a=3, op_b=2 -> done in cycle 5, result=6; op_b=0 -> done in cycle 3, result=0.
REQ-034 SHALL cover: start held high through DONE -> back-to-back operation accepted in the DONE cycle, and start ignored while busy.
